btb_update_scheduler: RTL and testbench

Sequences all writes into the branch target buffer of the fetch-stage dynamic branch predictor. It performs the post-reset and on-demand BTB invalidation sweep and detects mispredictions at execute-stage resolution. Resolved branches/jumps are queued and drained at one BTB write per cycle through a single registered write port. It sits between the execute stage (resolution source) and the predictor's BTB (write sink). While it is busy, it tells fetch to suppress predictions.

---
 rtl/btb_update_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_btb_update_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_scheduler.sv
`default_nettype none
//==============================================================================
// btb_update_scheduler - BTB invalidation sweep and resolved-branch update
// sequencer driving a single registered BTB write port.   Rev 1.0
//==============================================================================
module btb_update_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int BTB_ROWS   = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int IW = $clog2(BTB_ROWS),
    localparam int TW = DATA_WIDTH - IW - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_valid_e,
    input  logic [DATA_WIDTH-1:0] res_pc_e,
    input  logic [DATA_WIDTH-1:0] res_target_e,
    input  logic                  res_taken_e,
    input  logic                  res_uncond_e,
    input  logic                  res_pred_taken_e,
    input  logic [DATA_WIDTH-1:0] res_pred_target_e,
    input  logic                  flush_req,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    output logic                  btb_we,
    output logic [IW-1:0]         btb_idx,
    output logic                  btb_valid,
    output logic                  btb_pred,
    output logic                  btb_uncond,
    output logic [TW-1:0]         btb_tag,
    output logic [DATA_WIDTH-1:0] btb_target,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 + IW + TW + DATA_WIDTH;

    localparam logic [0:0] S_SWEEP = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam logic [IW:0] SWEEP_END = (IW+1)'(BTB_ROWS);
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    logic [0:0]            state_q, state_d;
    logic [IW:0]           sweep_cnt_q, sweep_cnt_d;
    logic [EW-1:0]         fifo_q [FIFO_DEPTH];
    logic [EW-1:0]         fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  btb_we_q, btb_we_d;
    logic [IW-1:0]         btb_idx_q, btb_idx_d;
    logic                  btb_valid_q, btb_valid_d;
    logic                  btb_pred_q, btb_pred_d;
    logic                  btb_uncond_q, btb_uncond_d;
    logic [TW-1:0]         btb_tag_q, btb_tag_d;
    logic [DATA_WIDTH-1:0] btb_target_q, btb_target_d;
    logic                  busy_q, busy_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  w_enq;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_accept;
    logic [EW-1:0]         w_new_entry;
    logic [EW-1:0]         w_head;

    assign mispredict_e  = res_valid_e &
                           ((res_pred_taken_e != res_taken_e) |
                            (res_taken_e & (res_pred_target_e != res_target_e)));
    assign redirect_pc_e = res_taken_e ? res_target_e : res_pc_e + DATA_WIDTH'(4);

    // Queue entry layout: {pred, uncond, idx, tag, target}; valid is implied.
    assign w_new_entry = {res_taken_e, res_uncond_e, res_pc_e[IW+1:2],
                          res_pc_e[DATA_WIDTH-1:IW+2], res_target_e};
    assign w_head      = fifo_q[rd_ptr_q];

    assign w_enq    = (state_q == S_RUN) & res_valid_e & ~flush_req;
    assign w_pop    = (state_q == S_RUN) & (count_q != '0);
    assign w_full   = (count_q == FIFO_FULL);
    assign w_accept = w_enq & ~(w_full & ~w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_SWEEP;
            sweep_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            btb_we_q     <= 1'b0;
            btb_idx_q    <= '0;
            btb_valid_q  <= 1'b0;
            btb_pred_q   <= 1'b0;
            btb_uncond_q <= 1'b0;
            btb_tag_q    <= '0;
            btb_target_q <= '0;
            busy_q       <= 1'b1;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            btb_we_q     <= btb_we_d;
            btb_idx_q    <= btb_idx_d;
            btb_valid_q  <= btb_valid_d;
            btb_pred_q   <= btb_pred_d;
            btb_uncond_q <= btb_uncond_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = S_SWEEP;
        end else if ((state_q == S_SWEEP) && (sweep_cnt_q == SWEEP_END)) begin
            state_d = S_RUN;
        end
    end

    // A flush immediately presents the row-0 invalidate, so the counter resumes at 1.
    always_comb begin
        sweep_cnt_d  = sweep_cnt_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        btb_we_d     = 1'b0;
        btb_idx_d    = btb_idx_q;
        btb_valid_d  = btb_valid_q;
        btb_pred_d   = btb_pred_q;
        btb_uncond_d = btb_uncond_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        drop_cnt_d   = drop_cnt_q;
        busy_d       = (state_d == S_SWEEP);

        if (flush_req) begin
            sweep_cnt_d  = (IW+1)'(1);
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            btb_we_d     = 1'b1;
            btb_idx_d    = '0;
            btb_valid_d  = 1'b0;
            btb_pred_d   = 1'b0;
            btb_uncond_d = 1'b0;
            btb_tag_d    = '0;
            btb_target_d = '0;
        end else if (state_q == S_SWEEP) begin
            if (sweep_cnt_q != SWEEP_END) begin
                sweep_cnt_d  = sweep_cnt_q + (IW+1)'(1);
                btb_we_d     = 1'b1;
                btb_idx_d    = sweep_cnt_q[IW-1:0];
                btb_valid_d  = 1'b0;
                btb_pred_d   = 1'b0;
                btb_uncond_d = 1'b0;
                btb_tag_d    = '0;
                btb_target_d = '0;
            end
        end else begin
            if (w_pop) begin
                btb_we_d     = 1'b1;
                btb_valid_d  = 1'b1;
                btb_pred_d   = w_head[EW-1];
                btb_uncond_d = w_head[EW-2];
                btb_idx_d    = w_head[DATA_WIDTH+TW+IW-1:DATA_WIDTH+TW];
                btb_tag_d    = w_head[DATA_WIDTH+TW-1:DATA_WIDTH];
                btb_target_d = w_head[DATA_WIDTH-1:0];
                rd_ptr_d     = rd_ptr_q + PW'(1);
            end
            if (w_accept) begin
                fifo_d[wr_ptr_q] = w_new_entry;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end else if (w_enq && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
            count_d = count_q + (PW+1)'(w_accept) - (PW+1)'(w_pop);
        end
    end

    assign btb_we     = btb_we_q;
    assign btb_idx    = btb_idx_q;
    assign btb_valid  = btb_valid_q;
    assign btb_pred   = btb_pred_q;
    assign btb_uncond = btb_uncond_q;
    assign btb_tag    = btb_tag_q;
    assign btb_target = btb_target_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_scheduler.sv
`default_nettype none
//==============================================================================
// tb_btb_update_scheduler - randomized scoreboard bench for btb_update_scheduler.
//==============================================================================
module tb_btb_update_scheduler;
    localparam int DW   = 32;
    localparam int ROWS = 16;
    localparam int IW   = 4;
    localparam int TW   = DW - IW - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          res_valid_e = 1'b0;
    logic [DW-1:0] res_pc_e = '0;
    logic [DW-1:0] res_target_e = '0;
    logic          res_taken_e = 1'b0;
    logic          res_uncond_e = 1'b0;
    logic          res_pred_taken_e = 1'b0;
    logic [DW-1:0] res_pred_target_e = '0;
    logic          flush_req = 1'b0;
    logic          mispredict_e;
    logic [DW-1:0] redirect_pc_e;
    logic          btb_we;
    logic [IW-1:0] btb_idx;
    logic          btb_valid, btb_pred, btb_uncond;
    logic [TW-1:0] btb_tag;
    logic [DW-1:0] btb_target;
    logic          busy;
    logic [7:0]    drop_cnt;

    btb_update_scheduler #(.DATA_WIDTH(DW), .BTB_ROWS(ROWS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid_e(res_valid_e), .res_pc_e(res_pc_e), .res_target_e(res_target_e),
        .res_taken_e(res_taken_e), .res_uncond_e(res_uncond_e),
        .res_pred_taken_e(res_pred_taken_e), .res_pred_target_e(res_pred_target_e),
        .flush_req(flush_req), .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e),
        .btb_we(btb_we), .btb_idx(btb_idx), .btb_valid(btb_valid), .btb_pred(btb_pred),
        .btb_uncond(btb_uncond), .btb_tag(btb_tag), .btb_target(btb_target),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic          valid;
        logic          pred;
        logic          uncond;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [DW-1:0] target;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned run_edge = ROWS + 1;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: every write the BTB port must show, tagged with its edge number.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            cyc = 0;
            for (int r = 0; r < ROWS; r++)
                exp_q.push_back('{cyc: r + 1, valid: 1'b0, pred: 1'b0, uncond: 1'b0,
                                  idx: IW'(r), tag: '0, target: '0});
            run_edge = ROWS + 1;
        end else begin
            cyc++;
            if (flush_req) begin
                while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
                for (int r = 0; r < ROWS; r++)
                    exp_q.push_back('{cyc: cyc + r, valid: 1'b0, pred: 1'b0, uncond: 1'b0,
                                      idx: IW'(r), tag: '0, target: '0});
                run_edge = cyc + ROWS;
            end else if (res_valid_e && cyc > run_edge) begin
                exp_q.push_back('{cyc: cyc + 1, valid: 1'b1, pred: res_taken_e,
                                  uncond: res_uncond_e, idx: res_pc_e[5:2],
                                  tag: res_pc_e[31:6], target: res_target_e});
            end
        end
    end

    // Monitor: compare each presented write against the scoreboard head.
    initial forever begin
        wr_t w;
        @(negedge clk);
        if (rst_n) begin
            if (btb_we) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: cycle %0d idx %0d valid %0b, expected no write",
                             cyc, btb_idx, btb_valid);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_idx", 64'(btb_idx), 64'(w.idx));
                    check("wr_valid", 64'(btb_valid), 64'(w.valid));
                    check("wr_pred", 64'(btb_pred), 64'(w.pred));
                    check("wr_uncond", 64'(btb_uncond), 64'(w.uncond));
                    check("wr_tag", 64'(btb_tag), 64'(w.tag));
                    check("wr_target", 64'(btb_target), 64'(w.target));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write: cycle %0d no btb_we, expected idx %0d",
                         cyc, exp_q[0].idx);
                void'(exp_q.pop_front());
            end
            check("busy", 64'(busy), 64'(cyc < run_edge));
            check("drop_cnt", 64'(drop_cnt), 64'd0);
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] tgt,
                         input logic tk, input logic unc, input logic ptk,
                         input logic [DW-1:0] ptgt, input logic fl);
        logic          e_mis;
        logic [DW-1:0] e_redir;
        @(negedge clk);
        res_valid_e       = v;
        res_pc_e          = pc;
        res_target_e      = tgt;
        res_taken_e       = tk;
        res_uncond_e      = unc;
        res_pred_taken_e  = ptk;
        res_pred_target_e = ptgt;
        flush_req         = fl;
        #1;
        e_mis   = v && ((ptk != tk) || (tk && ptgt != tgt));
        e_redir = tk ? tgt : pc + 32'd4;
        check("mispredict_e", 64'(mispredict_e), 64'(e_mis));
        check("redirect_pc_e", 64'(redirect_pc_e), 64'(e_redir));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drive_rand(input logic v, input logic fl);
        logic [DW-1:0] pc, tgt, ptgt;
        pc   = $urandom;
        tgt  = $urandom & 32'hFFFF_FFFC;
        ptgt = ($urandom_range(0, 1) == 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
        drive(v, pc, tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ptgt, fl);
    endtask

    task automatic check_reset_values();
        check("rst_btb_we", 64'(btb_we), 64'd0);
        check("rst_btb_idx", 64'(btb_idx), 64'd0);
        check("rst_btb_valid", 64'(btb_valid), 64'd0);
        check("rst_btb_pred", 64'(btb_pred), 64'd0);
        check("rst_btb_uncond", 64'(btb_uncond), 64'd0);
        check("rst_btb_tag", 64'(btb_tag), 64'd0);
        check("rst_btb_target", 64'(btb_target), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        drive(1'b1, 32'h0000_0124, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0000_1000, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        drive(1'b1, 32'h0000_2008, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 32'h3004, 1'b0);
        drive(1'b1, 32'h0000_200C, 32'h0000_3000, 1'b1, 1'b1, 1'b1, 32'h3000, 1'b0);
        idle(3);

        for (int i = 0; i < 8; i++) drive_rand(1'b1, 1'b0);
        idle(3);

        for (int i = 0; i < 3; i++) drive_rand(1'b1, 1'b0);
        drive_rand(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive_rand(1'b1, 1'b0);
        idle(4);
        drive_rand(1'b1, 1'b1);
        idle(20);

        for (int i = 0; i < 200; i++)
            drive_rand(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0));
        idle(20);

        drive_rand(1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        for (int i = 0; i < 4; i++) drive_rand(1'b1, 1'b0);

        idle(1);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes still outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
